// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with HI/LO architectural registers.
// Multiply and divide results are computed at issue and held in a pending
// register. They become visible in HI/LO after a fixed busy interval.
// Optional divider: define MDU_DIV_EN to enable div/divu. Without it they are no-ops.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned RES_W = 64;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
`endif

    logic [0:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [RES_W-1:0] pending, pending_next;
    logic             pending_wr, pending_wr_next;
    logic [31:0]      hi_next, lo_next;

    logic [RES_W-1:0] prod_u, prod_s;
    logic             is_mul;

    // Full-width products; sign-extended operands give the signed product in the low 64 bits
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);

`ifdef MDU_DIV_EN
    logic        is_div;
    logic [31:0] quot, rem;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Divider: zero divisor yields nothing useful (result discarded); signed overflow pinned
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b != '0) begin
            if (op == OP_DIVU) begin
                quot = a / b;
                rem  = a % b;
            end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                quot = a;
                rem  = '0;
            end else begin
                quot = 32'($signed(a) / $signed(b));
                rem  = 32'($signed(a) % $signed(b));
            end
        end
    end
`endif

    // Stall request to the front end while a mult/div-class op is blocked
    assign stall = md_req & (busy | start);

    // Next-state and datapath update
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        pending_next    = pending;
        pending_wr_next = pending_wr;
        hi_next         = hi;
        lo_next         = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        pending_next    = (op == OP_MULT) ? prod_s : prod_u;
                        pending_wr_next = 1'b1;
                        cnt_next        = MULT_LOAD;
                        state_next      = RUN;
`ifdef MDU_DIV_EN
                    end else if (is_div) begin
                        pending_next    = {rem, quot};
                        pending_wr_next = (b != '0);
                        cnt_next        = DIV_LOAD;
                        state_next      = RUN;
`endif
                    end else if (op == OP_MTHI) begin
                        hi_next = a;
                    end else if (op == OP_MTLO) begin
                        lo_next = a;
                    end
                end
            end
            RUN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    if (pending_wr) begin
                        hi_next = pending[63:32];
                        lo_next = pending[31:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, pending result and architectural HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= '0;
            pending_wr <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pending    <= pending_next;
            pending_wr <= pending_wr_next;
            hi         <= hi_next;
            lo         <= lo_next;
            busy       <= (state_next == RUN);
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mdu_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .md_req (md_req),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // After an issue edge has been taken: busy must stay high for n cycles, then drop
    task automatic run_busy(input string tag, input int n, input logic [31:0] hold_hi,
                            input logic [31:0] hold_lo);
        for (int i = 1; i < n; i++) begin
            step();
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        chk({tag, "_hi_hold"}, hi, hold_hi);
        chk({tag, "_lo_hold"}, lo, hold_lo);
        step();
        chk({tag, "_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        a      = '0;
        b      = '0;
        md_req = 1'b0;
        repeat (2) step();
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_hi",    hi,         32'd0);
        chk("rst_lo",    lo,         32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // mult issued on the first edge after reset release
        reset = 1'b0;
        start = 1'b1; op = 3'b000; a = 32'hFFFF_FFFF; b = 32'd2;
        #1 chk("stall_idle_nomd", 32'(stall), 32'd0);
        md_req = 1'b1;
        #1 chk("stall_idle_start", 32'(stall), 32'd1);
        md_req = 1'b0;
        step();
        start = 1'b0;
        chk("mult_busy1", 32'(busy), 32'd1);
        run_busy("mult", 5, 32'd0, 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        md_req = 1'b1;
        #1 chk("stall_idle_md_nostart", 32'(stall), 32'd0);
        md_req = 1'b0;

        // multu
        start = 1'b1; op = 3'b001; a = 32'hFFFF_FFFF; b = 32'd2;
        step();
        start = 1'b0;
        chk("multu_busy1", 32'(busy), 32'd1);
        run_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // mult with an mthi attempted during RUN cycle 2, and stall behaviour
        start = 1'b1; op = 3'b000; a = 32'h0001_0000; b = 32'h0003_0000;
        step();
        start = 1'b0;
        step();
        start = 1'b1; op = 3'b100; a = 32'h55; md_req = 1'b1;
        #1 chk("stall_run_md", 32'(stall), 32'd1);
        step();
        start = 1'b0; op = 3'b110;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_hi",   hi,        32'h0000_0001);
        step();
        md_req = 1'b0;
        #1 chk("stall_run_nomd", 32'(stall), 32'd0);
        chk("ign_busy2", 32'(busy), 32'd1);
        step();
        chk("ign_busy3", 32'(busy), 32'd1);
        step();
        chk("ign_done", 32'(busy), 32'd0);
        chk("ign_hi_prod", hi, 32'h0000_0003);
        chk("ign_lo_prod", lo, 32'h0000_0000);

        // mthi / mtlo single-edge writes
        start = 1'b1; op = 3'b100; a = 32'h0000_AAAA;
        step();
        chk("mthi_hi",   hi,        32'h0000_AAAA);
        chk("mthi_busy", 32'(busy), 32'd0);
        op = 3'b101; a = 32'h0000_BBBB;
        step();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_BBBB);
        chk("mtlo_hi", hi, 32'h0000_AAAA);

`ifdef MDU_DIV_EN
        // signed divide
        start = 1'b1; op = 3'b010; a = 32'hFFFF_FFF9; b = 32'd2;
        step();
        start = 1'b0;
        chk("div_busy1", 32'(busy), 32'd1);
        run_busy("div", 10, 32'h0000_AAAA, 32'h0000_BBBB);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // divide by zero: busy for full duration, HI/LO untouched
        start = 1'b1; op = 3'b011; a = 32'd7; b = 32'd0;
        step();
        start = 1'b0;
        chk("divz_busy1", 32'(busy), 32'd1);
        run_busy("divz", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        // signed overflow
        start = 1'b1; op = 3'b010; a = 32'h8000_0000; b = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        run_busy("divovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        // restore known HI/LO for the reset scenario
        start = 1'b1; op = 3'b100; a = 32'h0000_AAAA;
        step();
        start = 1'b0;
`else
        // divider absent: div/divu are no-ops
        start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd3;
        step();
        start = 1'b0;
        chk("nodiv_busy", 32'(busy), 32'd0);
        start = 1'b1; op = 3'b011;
        step();
        start = 1'b0;
        chk("nodivu_busy", 32'(busy), 32'd0);
        repeat (11) step();
        chk("nodiv_busy_late", 32'(busy), 32'd0);
        chk("nodiv_hi", hi, 32'h0000_AAAA);
        chk("nodiv_lo", lo, 32'h0000_BBBB);
`endif

        // reset pulsed during RUN cycle 3 of a long op
`ifdef MDU_DIV_EN
        start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
`else
        start = 1'b1; op = 3'b000; a = 32'd5; b = 32'd6;
`endif
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_hi",   hi,        32'h0000_AAAA);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_hi",   hi,        32'd0);
        chk("arst_lo",   lo,        32'd0);
        #2 reset = 1'b0;
        start = 1'b1; op = 3'b101; a = 32'h0000_1234;
        step();
        start = 1'b0;
        chk("post_rst_lo",   lo,        32'h0000_1234);
        chk("post_rst_hi",   hi,        32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (12) step();
        chk("no_stale_lo",   lo,        32'h0000_1234);
        chk("no_stale_hi",   hi,        32'd0);
        chk("no_stale_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage issue strobe for the op on `op`.
REQ-006 SHALL have port op  input  3  operation code:
  - 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo
  - 110 and 111 are no-op.
REQ-007 SHALL have port a  input  32  rs operand, already forwarded.
REQ-008 SHALL have port b  input  32  rt operand, already forwarded.
REQ-009 SHALL have port md_req  input  1  D stage holds any mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port busy  output  1  multicycle operation in progress.
REQ-011 SHALL have port stall  output  1  freeze request to F/D for the pipeline hazard logic.
REQ-012 SHALL have port hi  output  32  architectural HI.
REQ-013 SHALL have port lo  output  32  architectural LO.

Function
REQ-014 SHALL implement two states, IDLE and RUN, plus a 4-bit down-counter and 64-bit pending-result register.
REQ-015 SHALL, in IDLE with start=1 and op in {mult, multu, div, divu}:
  - capture the result into pending;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - enter RUN.
REQ-016 SHALL hold busy=1 exactly while in RUN, i.e. for N cycles following the start edge, where N is the loaded count.
REQ-017 SHALL decrement the counter each RUN cycle; on the edge the counter reaches 0, SHALL write pending to HI/LO and return to IDLE, with busy=0 in the same cycle HI/LO show the new value.
REQ-018 SHALL compute mult/multu as the signed/unsigned 64-bit product, {hi,lo} = a*b.
REQ-019 SHALL compute div/divu with lo=quotient and hi=remainder:
  - signed quotient truncates toward zero; remainder takes the dividend's sign;
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-020 SHALL, for a divide by b=0, still run DIV_CYCLES with busy=1 and leave HI/LO unchanged at completion.
REQ-021 SHALL execute mthi/mtlo in IDLE with start=1 as a single-edge write of `a` to HI or LO, with no busy.
REQ-022 SHALL ignore start while in RUN: no restart, no mthi/mtlo effect, counter undisturbed.
REQ-023 SHALL drive stall = md_req & (busy | start), combinationally.
REQ-024 SHALL give `hi` and `lo` directly from registers; mfhi/mflo read them with no internal bypass.

Reset
REQ-025 SHALL, on reset=1 at any time including mid-RUN, asynchronously force:
  - state IDLE, counter 0, pending 0;
  - hi=0, lo=0, busy=0;
  - any in-flight operation is discarded.
REQ-026 SHALL accept a new start on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL, with macro MDU_DIV_EN defined, implement div/divu as specified above.
REQ-028 SHALL, without MDU_DIV_EN, instantiate no divider and treat div/divu as no-ops: no busy, HI/LO unchanged; mult, multu, mthi and mtlo are unaffected.

Verification
REQ-029 SHALL verify: mult a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
REQ-030 SHALL verify: multu a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
REQ-031 SHALL verify: div a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; then divu a=7 b=0 -> HI/LO unchanged after 10 cycles.
REQ-032 SHALL verify: divu started, reset pulsed on RUN cycle 3 -> busy=0, hi=lo=0 immediately; mtlo a=0x1234 next cycle -> lo=0x1234.
REQ-033 SHALL verify: mult in progress, start with mthi a=0x55 at RUN cycle 2 -> ignored, hi equals the product result; md_req=1 during RUN -> stall=1, and md_req=0 -> stall=0.
REQ-034 SHALL verify: build without MDU_DIV_EN, div a=9 b=3 -> busy stays 0, hi/lo unchanged.
